// File: rtl/mix_pkg.sv
// Shared types, lane constants and multiply-add tables for the 8-lane mixing datapath.
package mix_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned WIDTH = 32;

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    // Packed so lane i sits at bits [32i+31:32i], matching the flat seed/result buses.
    typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

    // Listed lane 7 first because packed concatenation fills from the top index down.
    localparam lane_vec_t MA = {32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3, 32'd2};
    localparam lane_vec_t AA = {32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3};
    localparam lane_vec_t MB = {32'd87, 32'd35, 32'd13, 32'd5, 32'd3, 32'd3, 32'd3, 32'd2};
    localparam lane_vec_t AB = {32'd343, 32'd216, 32'd125, 32'd64, 32'd27, 32'd8, 32'd1, 32'd0};

    function automatic int unsigned lane_idx(input int unsigned i, input int unsigned off);
        return (i + off) % LANES;
    endfunction

endpackage

// File: rtl/mix_stage_alu.sv
// Combinational single-stage mixer: applies stage S0..S7 to all eight lanes, lane 0 first.
module mix_stage_alu
    import mix_pkg::*;
(
    input  lane_vec_t  lanes,
    input  logic [2:0] stage,
    output lane_vec_t  mixed
);

    lane_vec_t v;

    // Updating v in place gives lanes below i their new value and lanes i and above their old.
    always_comb begin
        v = lanes;
        for (int unsigned i = 0; i < LANES; i++) begin
            unique case (stage)
                3'd0: v[i] = v[i] + WIDTH'(i);
                3'd1: v[i] = v[i] + v[lane_idx(i, 7)];
                3'd2: v[i] = v[i] + v[lane_idx(i, 1)] - v[lane_idx(i, 5)];
                3'd3: v[i] = v[i] ^ (v[lane_idx(i, 3)] << 16);
                3'd4: v[i] = v[i] - (v[lane_idx(i, 2)] >> 17) + (v[lane_idx(i, 4)] >> 12);
                3'd5: v[i] = v[i] + v[lane_idx(i, 7)] - v[lane_idx(i, 6)];
                3'd6: v[i] = v[i] * MA[i] + AA[i];
                default: v[i] = v[i] * MB[i] + AB[i];
            endcase
        end
    end

    assign mixed = v;

endmodule

// File: rtl/mix_round_sequencer.sv
// Round sequencer: one mixing stage per clock, start/busy/done handshake, programmable rounds.
// Define MIX_ABORT_EN to add an abort input that cancels a run without a done pulse.
module mix_round_sequencer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RND_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef MIX_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [RND_W-1:0]       rounds,
    input  logic [LANES*WIDTH-1:0] init_data,
    output logic                   busy,
    output logic                   done,
    output logic [LANES*WIDTH-1:0] result,
    output logic [2:0]             stage_idx
);

    import mix_pkg::*;

    state_t           state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [RND_W-1:0] rounds_q, rounds_d;
    lane_vec_t        lanes_q, lanes_d;
    lane_vec_t        result_q, result_d;
    logic             done_q, done_d;
    lane_vec_t        mixed;
    logic             last_round;

    mix_stage_alu u_alu (
        .lanes (lanes_q),
        .stage (stage_q),
        .mixed (mixed)
    );

    // rounds_q is nonzero whenever RUN is entered, so the subtraction cannot wrap in use.
    assign last_round = (round_q == rounds_q - RND_W'(1));

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        round_d  = round_q;
        rounds_d = rounds_q;
        lanes_d  = lanes_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lanes_d  = init_data;
                    rounds_d = rounds;
                    stage_d  = '0;
                    round_d  = '0;
                    if (rounds == '0) begin
                        result_d = init_data;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                lanes_d = mixed;
                stage_d = stage_q + 3'd1;
                if (stage_q == 3'd7) begin
                    round_d = round_q + RND_W'(1);
                    if (last_round) begin
                        result_d = mixed;
                        done_d   = 1'b1;
                        round_d  = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef MIX_ABORT_EN
        // Abort freezes the working lanes and leaves the last completed result visible.
        if (state_q == RUN && abort) begin
            state_d  = IDLE;
            stage_d  = '0;
            round_d  = '0;
            lanes_d  = lanes_q;
            result_d = result_q;
            done_d   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            round_q  <= '0;
            rounds_q <= '0;
            lanes_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            round_q  <= round_d;
            rounds_q <= rounds_d;
            lanes_q  <= lanes_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign stage_idx = stage_q;

endmodule
